// File: rtl/corefifo_pkg.sv
// Shared pointer helpers for the CoreFIFO read- and write-side controllers.
// Helpers work on a wide pointer type; callers size-cast to their own pointer width.
package corefifo_pkg;

    localparam int MAX_PTRW = 32;

    typedef logic [MAX_PTRW-1:0] ptr_t;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended Gray input decodes correctly, because leading zeros leave the prefix XOR unchanged.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[MAX_PTRW-1] = g[MAX_PTRW-1];
        for (int i = MAX_PTRW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Occupancy from the two pointers, modulo 2**ptrw.
    function automatic ptr_t ptr_level(input ptr_t wbin, input ptr_t rbin, input int ptrw);
        ptr_t mask;
        mask = (ptr_t'(1) << ptrw) - ptr_t'(1);
        return (wbin - rbin) & mask;
    endfunction

endpackage

// File: rtl/corefifo_rd_ptr_ctrl.sv
// Read-domain pointer controller of the dual-clock CoreFIFO: Gray read pointer,
// RAM read address/enable, and registered empty / almost-empty / level / underflow flags.
module corefifo_rd_ptr_ctrl
    import corefifo_pkg::*;
#(
    parameter int ADDRWIDTH = 3,
    parameter int AE_THRESH = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 re,
    input  logic [ADDRWIDTH:0]   wptr_gray_sync,
    output logic [ADDRWIDTH:0]   rptr_gray,
    output logic [ADDRWIDTH-1:0] raddr,
    output logic                 ren_mem,
    output logic                 dvld,
    output logic                 empty,
    output logic                 aempty,
    output logic [ADDRWIDTH:0]   rd_cnt,
    output logic                 underflow
);

    localparam int PTRW = ptr_width(ADDRWIDTH);
    localparam logic [PTRW-1:0] AE_LIMIT = PTRW'(AE_THRESH);

    logic [PTRW-1:0] rbin_reg;
    logic [PTRW-1:0] rbin_next;
    logic [PTRW-1:0] rgray_next;
    logic [PTRW-1:0] wbin;
    logic [PTRW-1:0] level_next;
    logic            accept;

    // Flags are computed from the next read pointer, so the last read closes availability on the same edge.
    always_comb begin
        wbin       = PTRW'(gray2bin(ptr_t'(wptr_gray_sync)));
        accept     = re & ~empty;
        rbin_next  = rbin_reg + PTRW'(accept);
        rgray_next = PTRW'(bin2gray(ptr_t'(rbin_next)));
        level_next = PTRW'(ptr_level(ptr_t'(wbin), ptr_t'(rbin_next), PTRW));
    end

    assign ren_mem = accept;
    assign raddr   = rbin_reg[ADDRWIDTH-1:0];

    // rptr_gray must come straight from a flop: the write domain samples it asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rbin_reg  <= '0;
            rptr_gray <= '0;
            empty     <= 1'b1;
            aempty    <= 1'b1;
            rd_cnt    <= '0;
            dvld      <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rbin_reg  <= rbin_next;
            rptr_gray <= rgray_next;
            empty     <= (rgray_next == wptr_gray_sync);
            aempty    <= (level_next <= AE_LIMIT);
            rd_cnt    <= level_next;
            dvld      <= accept;
            underflow <= re & empty;
        end
    end

endmodule

// File: tb/tb_corefifo_rd_ptr_ctrl.sv
// Self-checking bench for corefifo_rd_ptr_ctrl (ADDRWIDTH=3, AE_THRESH=1): vector table,
// hand-written corner sequences and random traffic against an occupancy-count model.
module tb_corefifo_rd_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       re;
    logic [3:0] wptr_gray_sync;
    logic [3:0] rptr_gray;
    logic [2:0] raddr;
    logic       ren_mem;
    logic       dvld;
    logic       empty;
    logic       aempty;
    logic [3:0] rd_cnt;
    logic       underflow;

    corefifo_rd_ptr_ctrl #(.ADDRWIDTH(3), .AE_THRESH(1)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .re            (re),
        .wptr_gray_sync(wptr_gray_sync),
        .rptr_gray     (rptr_gray),
        .raddr         (raddr),
        .ren_mem       (ren_mem),
        .dvld          (dvld),
        .empty         (empty),
        .aempty        (aempty),
        .rd_cnt        (rd_cnt),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: total words written / read since reset as plain integers.
    int   m_r;
    int   m_w;
    logic m_empty;

    typedef struct {
        logic       re;
        int         w;
        logic       ren;
        logic [2:0] raddr;
        logic       empty;
        logic [3:0] rd_cnt;
        logic       aempty;
        logic       dvld;
        logic       uf;
        logic [3:0] rgray;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [3:0] gray4(input int b);
        int m;
        m = b % 16;
        return 4'(m ^ (m >> 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_aempty"}, aempty, 1);
        chk({tag, "_rptr_gray"}, rptr_gray, 0);
        chk({tag, "_rd_cnt"}, rd_cnt, 0);
        chk({tag, "_ren_mem"}, ren_mem, 0);
        chk({tag, "_raddr"}, raddr, 0);
        chk({tag, "_dvld"}, dvld, 0);
        chk({tag, "_underflow"}, underflow, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        re = 1'b1;
        wptr_gray_sync = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        rstn = 1'b1;
        re = 1'b0;
        m_r = 0;
        m_w = 0;
        m_empty = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock of traffic: drive, check combinational read port, clock, check registered state.
    task automatic model_cycle(input logic re_i, input int w_new);
        logic acc;
        logic uf;
        int   lvl;
        re = re_i;
        wptr_gray_sync = gray4(w_new);
        #1;
        acc = re_i && !m_empty;
        uf  = re_i && m_empty;
        chk("ren_mem", ren_mem, acc);
        chk("raddr", raddr, m_r % 8);
        @(posedge clk);
        #1;
        m_r = m_r + (acc ? 1 : 0);
        m_w = w_new;
        lvl = m_w - m_r;
        m_empty = (lvl == 0);
        chk("rptr_gray", rptr_gray, gray4(m_r));
        chk("rd_cnt", rd_cnt, lvl);
        chk("empty", empty, m_empty);
        chk("aempty", aempty, lvl <= 1);
        chk("dvld", dvld, acc);
        chk("underflow", underflow, uf);
        $display("[TB] cyc re=%0d w=%0d r=%0d lvl=%0d rptr_gray=%b", re_i, m_w, m_r, lvl, rptr_gray);
    endtask

    initial begin
        logic [3:0] prev_gray;
        int         w_new;

        //           re  w   ren addr emp cnt ae dv uf gray
        vecs[0] = '{1'b0, 4,  1'b0, 3'd0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[1] = '{1'b1, 4,  1'b1, 3'd0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 4'b0001};
        vecs[2] = '{1'b1, 4,  1'b1, 3'd1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 4'b0011};
        vecs[3] = '{1'b1, 4,  1'b1, 3'd2, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 4'b0010};
        vecs[4] = '{1'b1, 4,  1'b1, 3'd3, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 4'b0110};
        vecs[5] = '{1'b1, 4,  1'b0, 3'd4, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 4'b0110};
        vecs[6] = '{1'b0, 4,  1'b0, 3'd4, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 4'b0110};
        vecs[7] = '{1'b0, 12, 1'b0, 3'd4, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 4'b0110};
        vecs[8] = '{1'b1, 12, 1'b1, 3'd4, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0, 4'b0111};

        rstn = 1'b0;
        re = 1'b0;
        wptr_gray_sync = 4'd0;
        #1;

        // Reset state, then the drain / underflow / full-level table.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            re = vecs[i].re;
            wptr_gray_sync = gray4(vecs[i].w);
            #1;
            chk("vec_ren_mem", ren_mem, vecs[i].ren);
            chk("vec_raddr", raddr, vecs[i].raddr);
            @(posedge clk);
            #1;
            chk("vec_empty", empty, vecs[i].empty);
            chk("vec_rd_cnt", rd_cnt, vecs[i].rd_cnt);
            chk("vec_aempty", aempty, vecs[i].aempty);
            chk("vec_dvld", dvld, vecs[i].dvld);
            chk("vec_underflow", underflow, vecs[i].uf);
            chk("vec_rptr_gray", rptr_gray, vecs[i].rgray);
            $display("[TB] vec %0d re=%0d w=%0d rd_cnt=%0d empty=%0d rptr_gray=%b",
                     i, vecs[i].re, vecs[i].w, rd_cnt, empty, rptr_gray);
        end
        // Underflow is a single-cycle pulse.
        re = 1'b0;
        @(posedge clk);
        #1;
        chk("underflow_clear", underflow, 0);

        // Full level seen from a zero read pointer.
        do_reset();
        model_cycle(1'b0, 8);
        chk("full_rd_cnt", rd_cnt, 8);
        chk("full_empty", empty, 0);
        chk("full_gray_in", wptr_gray_sync, 4'b1100);

        // Last entry read in the same cycle the write pointer advances.
        do_reset();
        model_cycle(1'b0, 1);
        model_cycle(1'b1, 2);
        chk("simul_rd_cnt", rd_cnt, 1);
        chk("simul_empty", empty, 0);
        chk("simul_dvld_before_rst", dvld, 1);

        // Asynchronous reset mid-read, observed before the next clock edge.
        re = 1'b1;
        wptr_gray_sync = gray4(3);
        rstn = 1'b0;
        #1;
        chk_reset_values("async_rst");
        $display("[TB] async reset mid-read: empty=%0d dvld=%0d rptr_gray=%b", empty, dvld, rptr_gray);

        // Pointer wrap with the write pointer kept ahead; one Gray bit per step.
        do_reset();
        prev_gray = rptr_gray;
        for (int i = 0; i < 20; i++) begin
            model_cycle(1'b1, m_r + 4);
            chk("gray_single_bit", $countones(rptr_gray ^ prev_gray) <= 1, 1);
            prev_gray = rptr_gray;
        end
        chk("wrap_reads", m_r, 19);

        // Random traffic; write pointer never runs more than a full FIFO ahead.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            w_new = m_w + int'($urandom_range(0, 2));
            if (w_new - m_r > 8) begin
                w_new = m_r + 8;
            end
            model_cycle($urandom_range(0, 99) < 60, w_new);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
